cartridge_cache_filler: RTL

- Miss-handling controller on the initiator side of the cartridge one-cycle cache's memory port.
- Sits between the core's cartridge read path, the cache and the slow backing cartridge store.
- On a read miss (cache reports DataReady low), asserts Delay to the catch-up counter (CCCU) and fetches the whole aligned line from backing store, lowest address first, writing each byte into the cache.
- When the line is complete it replays the core's read, which then hits.

---
 rtl/cartridge_cache_filler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cartridge_cache_filler.sv
// Miss-handling controller for the cartridge one-cycle cache: on a read miss it stalls the core,
// copies the aligned line from the slow backing store into the cache byte by byte, then replays the read.
module cartridge_cache_filler #(
    parameter int AddressBusWidth = 16,
    parameter int CacheLineBits   = 7,
    parameter int DataBusWidth    = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         CoreAccess,
    input  logic [AddressBusWidth-1:0]   CoreAddress,
    output logic                         Delay,
    output logic                         FillBusy,
    output logic                         CacheAccess,
    output logic                         CacheWrite,
    output logic [AddressBusWidth-1:0]   CacheAddress,
    output logic [8*DataBusWidth-1:0]    CacheDin,
    input  logic                         CacheDataReady,
    output logic                         RomAccess,
    output logic [AddressBusWidth-1:0]   RomAddress,
    input  logic                         RomReady,
    input  logic                         RomDataReady,
    input  logic [8*DataBusWidth-1:0]    RomDout
);

    localparam int AW = AddressBusWidth;
    localparam int DW = 8 * DataBusWidth;
    localparam logic [AW-1:0] OFFSET_MASK = AW'((1 << CacheLineBits) - 1);
    localparam logic [CacheLineBits-1:0] LAST_BYTE = {CacheLineBits{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        WRITE,
        RESUME
    } state_t;

    state_t                   state, state_d;
    logic [CacheLineBits-1:0] counter, counter_d;
    logic [AW-1:0]            line_base, line_base_d;
    logic [AW-1:0]            core_addr_q;
    logic [DW-1:0]            cache_din_q, cache_din_d;
    logic                     delay_q;
    logic                     miss;
    logic [AW-1:0]            line_addr;

    // The offset bits of line_base are always zero, so OR-ing the counter never carries into the tag.
    assign line_addr = line_base | {{(AW-CacheLineBits){1'b0}}, counter};
    assign miss      = CoreAccess && !CacheDataReady;

    always_comb begin
        state_d      = state;
        counter_d    = counter;
        line_base_d  = line_base;
        cache_din_d  = cache_din_q;
        CacheAccess  = 1'b0;
        CacheWrite   = 1'b0;
        CacheAddress = line_addr;
        RomAccess    = 1'b0;

        case (state)
            IDLE: begin
                CacheAccess  = CoreAccess;
                CacheAddress = CoreAddress;
                if (miss) begin
                    line_base_d = CoreAddress & ~OFFSET_MASK;
                    counter_d   = '0;
                    state_d     = REQUEST;
                end
            end
            REQUEST: begin
                RomAccess = 1'b1;
                if (RomReady) begin
                    // A zero-wait store returns data in the accept cycle itself.
                    if (RomDataReady) begin
                        cache_din_d = RomDout;
                        state_d     = WRITE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (RomDataReady) begin
                    cache_din_d = RomDout;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                CacheAccess = 1'b1;
                CacheWrite  = 1'b1;
                if (counter == LAST_BYTE) begin
                    state_d = RESUME;
                end else begin
                    counter_d = counter + 1'b1;
                    state_d   = REQUEST;
                end
            end
            RESUME: begin
                CacheAccess  = 1'b1;
                CacheAddress = core_addr_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            counter     <= '0;
            line_base   <= '0;
            cache_din_q <= '0;
            delay_q     <= 1'b0;
        end else begin
            state       <= state_d;
            counter     <= counter_d;
            line_base   <= line_base_d;
            cache_din_q <= cache_din_d;
            delay_q     <= (state_d != IDLE);
        end
    end

    // Original read address, replayed in RESUME; only meaningful while a fill is in flight.
    always_ff @(posedge Clk) begin
        if (state == IDLE && miss) begin
            core_addr_q <= CoreAddress;
        end
    end

    assign Delay      = delay_q;
    assign FillBusy   = (state != IDLE);
    assign CacheDin   = cache_din_q;
    assign RomAddress = line_addr;

endmodule
